// File: rtl/set_scan_ctrl.sv
// Scan controller for the set-evaluation datapath: walks LANES map-cell lanes across
// the membership map and counts the elements that satisfy the selected set expression.
module set_scan_ctrl #(
    parameter int LANES = 4,
    parameter int AW    = 6,
    parameter int CW    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic [LANES-1:0]      hit,
    output logic [LANES*AW-1:0]   addr,
    output logic [2*LANES-1:0]    sel,
    output logic                  busy,
    output logic                  valid,
    output logic [CW-1:0]         count
);

    localparam int DEPTH = 1 << AW;
    localparam int NPAIR = LANES / 2;
    localparam int NTRI  = LANES / 3;
    localparam int BW    = AW + 2;
    localparam int SW    = $clog2(LANES + 1);
    localparam int ADDW  = (CW + 1 > SW + 1) ? CW + 1 : SW + 1;
    localparam logic [CW-1:0] CMAX = '1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t              state_reg;
    logic [1:0]          mode_reg;
    logic [AW:0]         base_reg;

    logic [BW-1:0]       step;
    logic [BW-1:0]       base_step;
    logic                last_batch;
    logic [1:0]          cfg_mode;
    logic [BW-1:0]       cfg_base;
    logic [LANES*AW-1:0] cfg_addr;
    logic [2*LANES-1:0]  cfg_sel;
    logic [LANES-1:0]    lane_on;
    logic [NPAIR-1:0]    pair_and;
    logic [NPAIR-1:0]    pair_xor;
    logic [NTRI-1:0]     tri_maj;
    logic [SW-1:0]       batch;
    logic [ADDW-1:0]     sum_wide;
    logic [CW-1:0]       count_sat;

    // Lane-to-group mapping: returns {sel, addr} for one lane at a given batch base.
    function automatic logic [AW+1:0] lane_map(input logic [1:0] m, input logic [BW-1:0] b,
                                               input int lane);
        int            grp;
        logic [1:0]    role;
        logic          used;
        logic [BW-1:0] a;
        grp  = lane;
        role = 2'd0;
        used = 1'b1;
        case (m)
            2'd0: begin
                grp  = lane;
                role = 2'd0;
            end
            2'd1, 2'd2: begin
                grp  = lane / 2;
                role = 2'(lane % 2);
            end
            default: begin
                grp  = lane / 3;
                role = 2'(lane % 3);
                used = (lane < 3 * NTRI);
            end
        endcase
        a = b + BW'(grp);
        if (used && (a < BW'(DEPTH)))
            return {role, a[AW-1:0]};
        else
            return {2'd3, {AW{1'b0}}};
    endfunction

    always_comb begin
        case (mode_reg)
            2'd0:       step = BW'(LANES);
            2'd1, 2'd2: step = BW'(NPAIR);
            default:    step = BW'(NTRI);
        endcase
    end

    assign base_step  = {1'b0, base_reg} + step;
    assign last_batch = (base_step >= BW'(DEPTH));

    // In IDLE the lanes are preloaded for base 0 of the incoming mode; in SCAN for the next batch.
    assign cfg_mode = (state_reg == IDLE) ? mode : mode_reg;
    assign cfg_base = (state_reg == IDLE) ? '0 : base_step;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [AW+1:0] map;
            assign map                    = lane_map(cfg_mode, cfg_base, gi);
            assign cfg_addr[gi*AW +: AW]  = map[AW-1:0];
            assign cfg_sel[2*gi +: 2]     = map[AW+1:AW];
            assign lane_on[gi]            = (sel[2*gi +: 2] != 2'd3);
        end

        // A group is masked as a whole, so its first lane's select stands for the group.
        for (gi = 0; gi < NPAIR; gi++) begin : g_pair
            assign pair_and[gi] = lane_on[2*gi] & hit[2*gi] & hit[2*gi+1];
            assign pair_xor[gi] = lane_on[2*gi] & (hit[2*gi] ^ hit[2*gi+1]);
        end

        for (gi = 0; gi < NTRI; gi++) begin : g_tri
            assign tri_maj[gi] = lane_on[3*gi] &
                                 ((hit[3*gi] & hit[3*gi+1]) |
                                  (hit[3*gi] & hit[3*gi+2]) |
                                  (hit[3*gi+1] & hit[3*gi+2]));
        end
    endgenerate

    always_comb begin
        batch = '0;
        case (mode_reg)
            2'd0: begin
                for (int i = 0; i < LANES; i++)
                    batch = batch + SW'(hit[i] & lane_on[i]);
            end
            2'd1: begin
                for (int i = 0; i < NPAIR; i++)
                    batch = batch + SW'(pair_and[i]);
            end
            2'd2: begin
                for (int i = 0; i < NPAIR; i++)
                    batch = batch + SW'(pair_xor[i]);
            end
            default: begin
                for (int i = 0; i < NTRI; i++)
                    batch = batch + SW'(tri_maj[i]);
            end
        endcase
    end

    assign sum_wide  = ADDW'(count) + ADDW'(batch);
    assign count_sat = (sum_wide > ADDW'(CMAX)) ? CMAX : sum_wide[CW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            mode_reg  <= 2'd0;
            base_reg  <= '0;
            count     <= '0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            addr      <= '0;
            sel       <= '1;
        end else begin
            case (state_reg)
                IDLE: begin
                    valid <= 1'b0;
                    if (start) begin
                        mode_reg  <= mode;
                        base_reg  <= '0;
                        count     <= '0;
                        busy      <= 1'b1;
                        addr      <= cfg_addr;
                        sel       <= cfg_sel;
                        state_reg <= SCAN;
                    end
                end
                SCAN: begin
                    if (abort) begin
                        busy      <= 1'b0;
                        addr      <= '0;
                        sel       <= '1;
                        state_reg <= IDLE;
                    end else begin
                        count <= count_sat;
                        if (last_batch) begin
                            valid     <= 1'b1;
                            addr      <= '0;
                            sel       <= '1;
                            state_reg <= DONE;
                        end else begin
                            base_reg <= base_step[AW:0];
                            addr     <= cfg_addr;
                            sel      <= cfg_sel;
                        end
                    end
                end
                default: begin
                    valid     <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
